// File: rtl/rf_frontend_pkg.sv
// Shared constants and helpers for the RF frontend datapath blocks.
package rf_frontend_pkg;

  // Rounding modes for the post-sum shift.
  localparam int unsigned ROUND_TRUNC   = 0;
  localparam int unsigned ROUND_HALF_UP = 1;

  // Width of a sum or difference of two full-precision DW x DW products.
  function automatic int unsigned sum_width(input int unsigned data_width);
    return 2 * data_width + 1;
  endfunction

endpackage

// File: rtl/complex_mult_pipe_if.sv
// Streaming bus of the complex multiplier: input side, output side and overflow status.
interface complex_mult_pipe_if #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned OUTPUT_WIDTH = 18,
  parameter int unsigned TAG_WIDTH    = 2
);

  logic                           in_valid;
  logic                           in_ready;
  logic                           in_conj;
  logic [TAG_WIDTH-1:0]           in_tag;
  logic signed [DATA_WIDTH-1:0]   a_real;
  logic signed [DATA_WIDTH-1:0]   a_imag;
  logic signed [DATA_WIDTH-1:0]   b_real;
  logic signed [DATA_WIDTH-1:0]   b_imag;
  logic                           out_valid;
  logic                           out_ready;
  logic [TAG_WIDTH-1:0]           out_tag;
  logic signed [OUTPUT_WIDTH-1:0] result_real;
  logic signed [OUTPUT_WIDTH-1:0] result_imag;
  logic                           out_ovf;
  logic                           ovf_sticky;
  logic                           ovf_clr;

  // Producer/consumer side (drives samples, accepts results).
  modport master (
    output in_valid, in_conj, in_tag, a_real, a_imag, b_real, b_imag, out_ready, ovf_clr,
    input  in_ready, out_valid, out_tag, result_real, result_imag, out_ovf, ovf_sticky
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_conj, in_tag, a_real, a_imag, b_real, b_imag, out_ready, ovf_clr,
    output in_ready, out_valid, out_tag, result_real, result_imag, out_ovf, ovf_sticky
  );

endinterface

// File: rtl/cmult_round_sat.sv
// Combinational round, arithmetic shift and saturate/wrap of one result component.
module cmult_round_sat
  import rf_frontend_pkg::*;
#(
  parameter int unsigned SUM_WIDTH    = 33,
  parameter int unsigned OUTPUT_WIDTH = 18,
  parameter int unsigned SHIFT        = 15,
  parameter int unsigned ROUND_MODE   = ROUND_HALF_UP,
  parameter int unsigned SATURATE     = 1
) (
  input  logic signed [SUM_WIDTH-1:0]    sum_i,
  output logic signed [OUTPUT_WIDTH-1:0] res_o,
  output logic                           ovf_o
);

  // Two guard bits: one for the rounding add, one so the range limits are representable.
  localparam int unsigned WorkW  = ((SUM_WIDTH > OUTPUT_WIDTH) ? SUM_WIDTH : OUTPUT_WIDTH) + 2;
  localparam int unsigned RndPos = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [WorkW-1:0]        One      = WorkW'(1);
  localparam logic [WorkW-1:0]        MaxU     = (One << (OUTPUT_WIDTH - 1)) - One;
  localparam logic signed [WorkW-1:0] SatMax   = $signed(MaxU);
  localparam logic signed [WorkW-1:0] SatMin   = $signed(~MaxU);
  localparam logic signed [WorkW-1:0] RoundInc =
      (ROUND_MODE == ROUND_HALF_UP && SHIFT > 0) ? $signed(One << RndPos) : '0;

  logic signed [WorkW-1:0] ext;
  logic signed [WorkW-1:0] rounded;
  logic signed [WorkW-1:0] shifted;

  // Round, shift, then clamp or drop MSBs depending on SATURATE.
  always_comb begin
    ext     = {{(WorkW - SUM_WIDTH){sum_i[SUM_WIDTH-1]}}, sum_i};
    rounded = ext + RoundInc;
    shifted = rounded >>> SHIFT;
    ovf_o   = (shifted > SatMax) || (shifted < SatMin);
    res_o   = shifted[OUTPUT_WIDTH-1:0];
    if (SATURATE != 0 && ovf_o) begin
      res_o = shifted[WorkW-1] ? SatMin[OUTPUT_WIDTH-1:0] : SatMax[OUTPUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/complex_mult_pipe.sv
// Four-stage streaming signed complex multiplier with valid/ready backpressure,
// optional conjugate of b, rounding, saturation, tag passthrough and overflow flags.
module complex_mult_pipe
  import rf_frontend_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned OUTPUT_WIDTH = 18,
  parameter int unsigned SHIFT        = 15,
  parameter int unsigned ROUND_MODE   = ROUND_HALF_UP,
  parameter int unsigned SATURATE     = 1,
  parameter int unsigned TAG_WIDTH    = 2
) (
  input logic                clk,
  input logic                rst,
  complex_mult_pipe_if.slave bus_if
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam int unsigned SumW  = sum_width(DATA_WIDTH);

  // Stage 1: operands
  logic                         v1_q, conj1_q;
  logic [TAG_WIDTH-1:0]         tag1_q;
  logic signed [DATA_WIDTH-1:0] ar1_q, ai1_q, br1_q, bi1_q;
  // Stage 2: products
  logic                         v2_q, conj2_q;
  logic [TAG_WIDTH-1:0]         tag2_q;
  logic signed [ProdW-1:0]      rr_q, ii_q, ri_q, ir_q;
  logic signed [ProdW-1:0]      rr_d, ii_d, ri_d, ir_d;
  logic signed [ProdW-1:0]      ar_x, ai_x, br_x, bi_x;
  // Stage 3: sums
  logic                         v3_q;
  logic [TAG_WIDTH-1:0]         tag3_q;
  logic signed [SumW-1:0]       re3_q, im3_q, re3_d, im3_d;
  logic signed [SumW-1:0]       rr_s, ii_s, ri_s, ir_s;
  // Stage 4: outputs
  logic                           out_valid_q, out_ovf_q, ovf_sticky_q;
  logic [TAG_WIDTH-1:0]           out_tag_q;
  logic signed [OUTPUT_WIDTH-1:0] res_re_q, res_im_q;
  logic signed [OUTPUT_WIDTH-1:0] re_rs, im_rs;
  logic                           re_ovf, im_ovf;

  logic stall, en;

  // A held result freezes the whole pipeline; bubbles are kept in place.
  assign stall = out_valid_q & ~bus_if.out_ready;
  assign en    = ~stall;

  assign bus_if.in_ready    = en;
  assign bus_if.out_valid   = out_valid_q;
  assign bus_if.out_tag     = out_tag_q;
  assign bus_if.result_real = res_re_q;
  assign bus_if.result_imag = res_im_q;
  assign bus_if.out_ovf     = out_ovf_q;
  assign bus_if.ovf_sticky  = ovf_sticky_q;

  // S1: capture the accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      conj1_q <= 1'b0;
      tag1_q  <= '0;
      ar1_q   <= '0;
      ai1_q   <= '0;
      br1_q   <= '0;
      bi1_q   <= '0;
    end else if (en) begin
      v1_q <= bus_if.in_valid;
      if (bus_if.in_valid) begin
        conj1_q <= bus_if.in_conj;
        tag1_q  <= bus_if.in_tag;
        ar1_q   <= bus_if.a_real;
        ai1_q   <= bus_if.a_imag;
        br1_q   <= bus_if.b_real;
        bi1_q   <= bus_if.b_imag;
      end
    end
  end

  // S2 products at full width; sign-extend first so the (-2^(DW-1))^2 case cannot wrap.
  always_comb begin
    ar_x = {{DATA_WIDTH{ar1_q[DATA_WIDTH-1]}}, ar1_q};
    ai_x = {{DATA_WIDTH{ai1_q[DATA_WIDTH-1]}}, ai1_q};
    br_x = {{DATA_WIDTH{br1_q[DATA_WIDTH-1]}}, br1_q};
    bi_x = {{DATA_WIDTH{bi1_q[DATA_WIDTH-1]}}, bi1_q};
    rr_d = ar_x * br_x;
    ii_d = ai_x * bi_x;
    ri_d = ar_x * bi_x;
    ir_d = ai_x * br_x;
  end

  // S2 control: valid, conj and tag follow the products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      conj2_q <= 1'b0;
      tag2_q  <= '0;
    end else if (en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        conj2_q <= conj1_q;
        tag2_q  <= tag1_q;
      end
    end
  end

  // S2 product registers left without reset so they pack into DSP output registers.
  always_ff @(posedge clk) begin
    if (en && v1_q) begin
      rr_q <= rr_d;
      ii_q <= ii_d;
      ri_q <= ri_d;
      ir_q <= ir_d;
    end
  end

  // S3 sums; conj flips the sign of b_imag, i.e. of the ii and ri terms.
  always_comb begin
    rr_s = {rr_q[ProdW-1], rr_q};
    ii_s = {ii_q[ProdW-1], ii_q};
    ri_s = {ri_q[ProdW-1], ri_q};
    ir_s = {ir_q[ProdW-1], ir_q};
    if (conj2_q) begin
      re3_d = rr_s + ii_s;
      im3_d = ir_s - ri_s;
    end else begin
      re3_d = rr_s - ii_s;
      im3_d = ri_s + ir_s;
    end
  end

  // S3 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q   <= 1'b0;
      tag3_q <= '0;
      re3_q  <= '0;
      im3_q  <= '0;
    end else if (en) begin
      v3_q <= v2_q;
      if (v2_q) begin
        tag3_q <= tag2_q;
        re3_q  <= re3_d;
        im3_q  <= im3_d;
      end
    end
  end

  cmult_round_sat #(
    .SUM_WIDTH   (SumW),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .SHIFT       (SHIFT),
    .ROUND_MODE  (ROUND_MODE),
    .SATURATE    (SATURATE)
  ) u_rs_re (
    .sum_i(re3_q),
    .res_o(re_rs),
    .ovf_o(re_ovf)
  );

  cmult_round_sat #(
    .SUM_WIDTH   (SumW),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .SHIFT       (SHIFT),
    .ROUND_MODE  (ROUND_MODE),
    .SATURATE    (SATURATE)
  ) u_rs_im (
    .sum_i(im3_q),
    .res_o(im_rs),
    .ovf_o(im_ovf)
  );

  // S4 output register; data only moves on a valid sample so the last result is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      res_re_q    <= '0;
      res_im_q    <= '0;
      out_ovf_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= v3_q;
      if (v3_q) begin
        out_tag_q <= tag3_q;
        res_re_q  <= re_rs;
        res_im_q  <= im_rs;
        out_ovf_q <= re_ovf | im_ovf;
      end else begin
        out_ovf_q <= 1'b0;
      end
    end
  end

  // Sticky overflow: a setting transfer beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_q <= 1'b0;
    end else if (out_valid_q && bus_if.out_ready && out_ovf_q) begin
      ovf_sticky_q <= 1'b1;
    end else if (bus_if.ovf_clr) begin
      ovf_sticky_q <= 1'b0;
    end
  end

endmodule
